axi_to_mem_aw_beat_gen: RTL and testbench

- Downstream consumer of the AW-channel FIFO in axi_to_mem.
- Pops one AW burst descriptor at a time and expands it into one memory write-address request per beat (FIXED/INCR/WRAP) over a valid/ready handshake.
- Feeds the memory-request arbiter, which pairs each beat with its W data.

---
 rtl/axi_to_mem_pkg.sv | 65 ++++++
 rtl/axi_to_mem_addr_next.sv | 17 +
 rtl/axi_to_mem_aw_beat_gen.sv | 159 +++++++++++++++
 tb/tb_axi_to_mem_aw_beat_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_to_mem_pkg.sv
// rtl/axi_to_mem_pkg.sv - shared AW field layout, burst encodings, state enum and next-address helper
// Used by axi_to_mem_aw_beat_gen and axi_to_mem_addr_next.
package axi_to_mem_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam int unsigned AW_LEN_W    = 8;
   localparam int unsigned AW_SIZE_W   = 3;
   localparam int unsigned AW_BURST_W  = 2;
   localparam int unsigned AW_LOCK_W   = 1;
   localparam int unsigned AW_CACHE_W  = 4;
   localparam int unsigned AW_PROT_W   = 3;
   localparam int unsigned AW_QOS_W    = 4;
   localparam int unsigned AW_REGION_W = 4;
   localparam int unsigned AW_ATOP_W   = 6;

   // Offsets are measured from the top of the user field, which sits at the LSBs.
   localparam int unsigned AW_ATOP_OFF   = 0;
   localparam int unsigned AW_REGION_OFF = AW_ATOP_OFF + AW_ATOP_W;
   localparam int unsigned AW_QOS_OFF    = AW_REGION_OFF + AW_REGION_W;
   localparam int unsigned AW_PROT_OFF   = AW_QOS_OFF + AW_QOS_W;
   localparam int unsigned AW_CACHE_OFF  = AW_PROT_OFF + AW_PROT_W;
   localparam int unsigned AW_LOCK_OFF   = AW_CACHE_OFF + AW_CACHE_W;
   localparam int unsigned AW_BURST_OFF  = AW_LOCK_OFF + AW_LOCK_W;
   localparam int unsigned AW_SIZE_OFF   = AW_BURST_OFF + AW_BURST_W;
   localparam int unsigned AW_LEN_OFF    = AW_SIZE_OFF + AW_SIZE_W;
   localparam int unsigned AW_FIXED_W    = AW_LEN_OFF + AW_LEN_W;

   localparam int unsigned ADDR_CALC_W = 64;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   function automatic logic wrap_len_ok(input logic [AW_LEN_W-1:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Computed wide so the wrap-boundary compare never aliases at the top of the address space.
   function automatic logic [ADDR_CALC_W-1:0] addr_next(
      input logic [ADDR_CALC_W-1:0] addr,
      input logic [AW_SIZE_W-1:0]   size,
      input logic [AW_LEN_W-1:0]    len,
      input logic [AW_BURST_W-1:0]  burst
   );
      logic [ADDR_CALC_W-1:0] step;
      logic [ADDR_CALC_W-1:0] total;
      logic [ADDR_CALC_W-1:0] lower;
      logic [ADDR_CALC_W-1:0] incr;
      step  = 64'd1 << size;
      total = (ADDR_CALC_W'(len) + 64'd1) << size;
      lower = addr & ~(total - 64'd1);
      incr  = (addr & ~(step - 64'd1)) + step;
      if (burst == BURST_FIXED) begin
         return addr;
      end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
         return (incr == lower + total) ? lower : incr;
      end
      return incr;
   endfunction

endpackage

// File: rtl/axi_to_mem_addr_next.sv
// rtl/axi_to_mem_addr_next.sv - combinational next beat address for FIXED/INCR/WRAP bursts
// Address arithmetic wraps modulo 2^MemAddrWidth.
module axi_to_mem_addr_next
   import axi_to_mem_pkg::*;
#(
   parameter int unsigned MemAddrWidth = 32
) (
   input  logic [MemAddrWidth-1:0] addr_i,
   input  logic [AW_SIZE_W-1:0]    size_i,
   input  logic [AW_LEN_W-1:0]     len_i,
   input  logic [AW_BURST_W-1:0]   burst_i,
   output logic [MemAddrWidth-1:0] next_o
);

   assign next_o = MemAddrWidth'(addr_next(ADDR_CALC_W'(addr_i), size_i, len_i, burst_i));

endmodule

// File: rtl/axi_to_mem_aw_beat_gen.sv
// rtl/axi_to_mem_aw_beat_gen.sv - expands AW burst descriptors into per-beat write-address requests
// Optional atomic filtering under `AXI_TO_MEM_ATOP_FILTER_EN (adds atop_drop_o).
module axi_to_mem_aw_beat_gen
   import axi_to_mem_pkg::*;
#(
   parameter int unsigned IdWidth      = 4,
   parameter int unsigned MemAddrWidth = 32,
   parameter int unsigned UserWidth    = 1,
   parameter int unsigned DataWidth    = 64
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [IdWidth+MemAddrWidth+35+UserWidth-1:0] aw_i,
   input  logic                                        aw_valid_i,
   output logic                                        aw_ready_o,
   output logic                                        req_valid_o,
   input  logic                                        req_ready_i,
   output logic [MemAddrWidth-1:0]                     req_addr_o,
   output logic [IdWidth-1:0]                          req_id_o,
   output logic [UserWidth-1:0]                        req_user_o,
   output logic [2:0]                                  req_size_o,
   output logic                                        req_last_o,
   output logic                                        busy_o
`ifdef AXI_TO_MEM_ATOP_FILTER_EN
   ,
   output logic                                        atop_drop_o
`endif
);

   localparam logic [AW_SIZE_W-1:0] MaxSize = AW_SIZE_W'($clog2(DataWidth / 8));
   localparam int unsigned AddrOff = UserWidth + AW_FIXED_W;
   localparam int unsigned IdOff   = AddrOff + MemAddrWidth;

   logic [IdWidth-1:0]      aw_id;
   logic [MemAddrWidth-1:0] aw_addr;
   logic [AW_LEN_W-1:0]     aw_len;
   logic [AW_SIZE_W-1:0]    aw_size;
   logic [AW_SIZE_W-1:0]    aw_size_eff;
   logic [AW_BURST_W-1:0]   aw_burst;
   logic [UserWidth-1:0]    aw_user;
   logic                    unused_aw_fields;

   assign aw_id       = aw_i[IdOff +: IdWidth];
   assign aw_addr     = aw_i[AddrOff +: MemAddrWidth];
   assign aw_len      = aw_i[UserWidth + AW_LEN_OFF +: AW_LEN_W];
   assign aw_size     = aw_i[UserWidth + AW_SIZE_OFF +: AW_SIZE_W];
   assign aw_burst    = aw_i[UserWidth + AW_BURST_OFF +: AW_BURST_W];
   assign aw_user     = aw_i[UserWidth-1:0];
   assign aw_size_eff = (aw_size > MaxSize) ? MaxSize : aw_size;
   assign unused_aw_fields = ^aw_i[UserWidth + AW_ATOP_OFF +: (AW_BURST_OFF - AW_ATOP_OFF)];

   state_e                  state_q, state_d;
   logic [MemAddrWidth-1:0] addr_q, addr_d;
   logic [IdWidth-1:0]      id_q, id_d;
   logic [UserWidth-1:0]    user_q, user_d;
   logic [AW_SIZE_W-1:0]    size_q, size_d;
   logic [AW_LEN_W-1:0]     len_q, len_d;
   logic [AW_BURST_W-1:0]   burst_q, burst_d;
   logic [AW_LEN_W-1:0]     cnt_q, cnt_d;
   logic [MemAddrWidth-1:0] addr_nxt;
   logic                    pop;
   logic                    load;

`ifdef AXI_TO_MEM_ATOP_FILTER_EN
   logic aw_atop_hit;
   assign aw_atop_hit = (aw_i[UserWidth + AW_ATOP_OFF +: AW_ATOP_W] != '0);
   assign atop_drop_o = pop & aw_atop_hit;
`endif

   axi_to_mem_addr_next #(
      .MemAddrWidth(MemAddrWidth)
   ) i_addr_next (
      .addr_i (addr_q),
      .size_i (size_q),
      .len_i  (len_q),
      .burst_i(burst_q),
      .next_o (addr_nxt)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      user_d  = user_q;
      size_d  = size_q;
      len_d   = len_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            pop = aw_valid_i;
         end
         ST_BURST: begin
            if (req_ready_i) begin
               if (cnt_q == '0) begin
                  // Last beat leaves: chain straight into the next descriptor if one is waiting.
                  pop     = aw_valid_i;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d  = cnt_q - 8'd1;
                  addr_d = addr_nxt;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef AXI_TO_MEM_ATOP_FILTER_EN
      load = pop & ~aw_atop_hit;
`else
      load = pop;
`endif

      if (load) begin
         state_d = ST_BURST;
         addr_d  = aw_addr;
         id_d    = aw_id;
         user_d  = aw_user;
         size_d  = aw_size_eff;
         len_d   = aw_len;
         burst_d = aw_burst;
         cnt_d   = aw_len;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         id_q    <= '0;
         user_q  <= '0;
         size_q  <= '0;
         len_q   <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         user_q  <= user_d;
         size_q  <= size_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
      end
   end

   assign aw_ready_o  = pop;
   assign req_valid_o = (state_q == ST_BURST);
   assign busy_o      = (state_q == ST_BURST);
   assign req_last_o  = (state_q == ST_BURST) && (cnt_q == '0);
   assign req_addr_o  = addr_q;
   assign req_id_o    = id_q;
   assign req_user_o  = user_q;
   assign req_size_o  = size_q;

endmodule

// File: tb/tb_axi_to_mem_aw_beat_gen.sv
// tb/tb_axi_to_mem_aw_beat_gen.sv - self-checking bench for axi_to_mem_aw_beat_gen
// Honours `AXI_TO_MEM_ATOP_FILTER_EN when defined.
module tb_axi_to_mem_aw_beat_gen;

   localparam int IW = 4;
   localparam int AW = 32;
   localparam int UW = 1;
   localparam int DW = 64;
   localparam int DescW = IW + AW + 35 + UW;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic [DescW-1:0] aw_i = '0;
   logic             aw_valid_i = 1'b0;
   logic             aw_ready_o;
   logic             req_valid_o;
   logic             req_ready_i = 1'b0;
   logic [AW-1:0]    req_addr_o;
   logic [IW-1:0]    req_id_o;
   logic [UW-1:0]    req_user_o;
   logic [2:0]       req_size_o;
   logic             req_last_o;
   logic             busy_o;
`ifdef AXI_TO_MEM_ATOP_FILTER_EN
   logic             atop_drop_o;
`endif

   axi_to_mem_aw_beat_gen #(
      .IdWidth(IW), .MemAddrWidth(AW), .UserWidth(UW), .DataWidth(DW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .aw_i(aw_i), .aw_valid_i(aw_valid_i),
      .aw_ready_o(aw_ready_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
      .req_addr_o(req_addr_o), .req_id_o(req_id_o), .req_user_o(req_user_o),
      .req_size_o(req_size_o), .req_last_o(req_last_o), .busy_o(busy_o)
`ifdef AXI_TO_MEM_ATOP_FILTER_EN
      , .atop_drop_o(atop_drop_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [IW-1:0] id;
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [2:0]    size;
      logic [1:0]    burst;
      logic          lock;
      logic [3:0]    cache;
      logic [2:0]    prot;
      logic [3:0]    qos;
      logic [3:0]    region;
      logic [5:0]    atop;
      logic [UW-1:0] user;
      int            nb;
   } desc_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [IW-1:0] id;
      logic [UW-1:0] user;
      logic [2:0]    size;
      logic          last;
   } beat_t;

   desc_t         fifo[$];
   beat_t         pend[$];
   beat_t         exp_q[$];
   logic [AW-1:0] dir_addr[$];
   logic [2:0]    dir_size;
   bit            use_dir = 0;
   bit            ready_seq[$];
   int            ready_mode = 0;
   int            awr_cnt = 0;
   int            acc_cnt = 0;
   bit            prev_stall = 0;
   beat_t         prev_obs;
   int            n_tests = 0;
   int            n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DescW-1:0] pack(input desc_t d);
      return {d.id, d.addr, d.len, d.size, d.burst, d.lock, d.cache, d.prot, d.qos, d.region, d.atop, d.user};
   endfunction

   function automatic desc_t mk(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst);
      desc_t d;
      d.id = id; d.addr = addr; d.len = len; d.size = size; d.burst = burst;
      d.lock = 1'($urandom); d.cache = 4'($urandom); d.prot = 3'($urandom);
      d.qos = 4'($urandom); d.region = 4'($urandom); d.atop = '0;
      d.user = UW'($urandom); d.nb = 0;
      return d;
   endfunction

   // Reference expansion straight from the burst rules, in integer arithmetic.
   task automatic add_desc(input desc_t din);
      desc_t           d = din;
      beat_t           b;
      longint unsigned a, step, total, lower, nxt;
      int              se;
      bit              wrap_ok;
      b.id = d.id; b.user = d.user;
`ifdef AXI_TO_MEM_ATOP_FILTER_EN
      if (d.atop != 0) begin
         d.nb = 0;
         fifo.push_back(d);
         return;
      end
`endif
      if (use_dir) begin
         foreach (dir_addr[i]) begin
            b.addr = dir_addr[i]; b.size = dir_size; b.last = (i == dir_addr.size() - 1);
            pend.push_back(b);
         end
         d.nb = dir_addr.size();
      end else begin
         se = (d.size > 3) ? 3 : int'(d.size);
         step = longint'(1) << se;
         wrap_ok = (d.len == 1) || (d.len == 3) || (d.len == 7) || (d.len == 15);
         a = longint'(d.addr);
         for (int n = 0; n <= int'(d.len); n++) begin
            b.addr = a[AW-1:0]; b.size = 3'(se); b.last = (n == int'(d.len));
            pend.push_back(b);
            if (d.burst == 2'b00) nxt = a;
            else begin
               nxt = a - (a % step) + step;
               if (d.burst == 2'b10 && wrap_ok) begin
                  total = (longint'(d.len) + 1) * step;
                  lower = a - (a % total);
                  if (nxt == lower + total) nxt = lower;
               end
            end
            a = nxt % (longint'(1) << AW);
         end
         d.nb = int'(d.len) + 1;
      end
      fifo.push_back(d);
   endtask

   task automatic step_cycle();
      beat_t f;
      desc_t d;
      bit    ev, ea;
      @(negedge clk_i);
      aw_valid_i = (fifo.size() != 0);
      aw_i = aw_valid_i ? pack(fifo[0]) : '0;
      if (ready_seq.size() != 0) req_ready_i = ready_seq.pop_front();
      else if (ready_mode == 0) req_ready_i = 1'b1;
      else req_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      ev = (exp_q.size() != 0);
      check_eq("req_valid", 64'(req_valid_o), 64'(ev));
      check_eq("busy", 64'(busy_o), 64'(ev));
      if (ev) begin
         f = exp_q[0];
         check_eq("req_addr", 64'(req_addr_o), 64'(f.addr));
         check_eq("req_id", 64'(req_id_o), 64'(f.id));
         check_eq("req_user", 64'(req_user_o), 64'(f.user));
         check_eq("req_size", 64'(req_size_o), 64'(f.size));
         check_eq("req_last", 64'(req_last_o), 64'(f.last));
      end else begin
         check_eq("req_last_idle", 64'(req_last_o), 64'd0);
      end
      if (prev_stall) begin
         check_eq("stall_addr", 64'(req_addr_o), 64'(prev_obs.addr));
         check_eq("stall_last", 64'(req_last_o), 64'(prev_obs.last));
         check_eq("stall_size", 64'(req_size_o), 64'(prev_obs.size));
      end
      ea = aw_valid_i && (!ev || (req_ready_i && f.last));
      check_eq("aw_ready", 64'(aw_ready_o), 64'(ea));
      prev_stall = req_valid_o && !req_ready_i;
      prev_obs.addr = req_addr_o; prev_obs.last = req_last_o; prev_obs.size = req_size_o;
      if (ev && req_ready_i) begin
         void'(exp_q.pop_front());
         acc_cnt++;
      end
      if (ea) begin
         d = fifo.pop_front();
         awr_cnt++;
`ifdef AXI_TO_MEM_ATOP_FILTER_EN
         check_eq("atop_drop", 64'(atop_drop_o), 64'(d.atop != 0));
`endif
         repeat (d.nb) exp_q.push_back(pend.pop_front());
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && (fifo.size() != 0 || exp_q.size() != 0); i++) step_cycle();
      check_eq("drain_done", 64'(fifo.size() + exp_q.size()), 64'd0);
      step_cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, 64'(req_valid_o), 64'd0);
      check_eq({tag, "_last"}, 64'(req_last_o), 64'd0);
      check_eq({tag, "_busy"}, 64'(busy_o), 64'd0);
      check_eq({tag, "_addr"}, 64'(req_addr_o), 64'd0);
      check_eq({tag, "_id"}, 64'(req_id_o), 64'd0);
      check_eq({tag, "_user"}, 64'(req_user_o), 64'd0);
      check_eq({tag, "_size"}, 64'(req_size_o), 64'd0);
   endtask

   initial begin
      desc_t d;
      int    a0;
      repeat (3) @(negedge clk_i);
      #1;
      check_reset_outputs("rst");
      check_eq("rst_aw_ready", 64'(aw_ready_o), 64'd0);
      rst_ni = 1'b1;

      // INCR unaligned start
      awr_cnt = 0; acc_cnt = 0; use_dir = 1; dir_size = 3'd3;
      dir_addr = '{32'h1004, 32'h1008, 32'h1010, 32'h1018};
      add_desc(mk(4'h3, 32'h1004, 8'd3, 3'd3, 2'b01));
      drain();
      check_eq("incr_aw_pops", 64'(awr_cnt), 64'd1);
      check_eq("incr_beats", 64'(acc_cnt), 64'd4);

      // WRAP
      dir_addr = '{32'h38, 32'h20, 32'h28, 32'h30};
      add_desc(mk(4'h5, 32'h38, 8'd3, 3'd3, 2'b10));
      drain();

      // FIXED with stalls
      acc_cnt = 0;
      dir_addr = '{32'h200, 32'h200, 32'h200};
      add_desc(mk(4'h9, 32'h200, 8'd2, 3'd2, 2'b00));
      dir_size = 3'd2;
      pend[pend.size()-1].size = 3'd2; pend[pend.size()-2].size = 3'd2; pend[pend.size()-3].size = 3'd2;
      ready_seq = '{1, 1, 0, 1, 0, 1};
      drain();
      check_eq("fixed_beats", 64'(acc_cnt), 64'd3);

      // Back-to-back single-beat bursts
      awr_cnt = 0; dir_size = 3'd3;
      dir_addr = '{32'h4000};
      add_desc(mk(4'h1, 32'h4000, 8'd0, 3'd3, 2'b01));
      dir_addr = '{32'h5008};
      add_desc(mk(4'h2, 32'h5008, 8'd0, 3'd3, 2'b01));
      drain();
      check_eq("b2b_aw_pops", 64'(awr_cnt), 64'd2);

      // Oversized beat size is clipped
      dir_addr = '{32'h0, 32'h8};
      add_desc(mk(4'hA, 32'h0, 8'd1, 3'd7, 2'b01));
      drain();
      use_dir = 0;

      // Reset in the middle of a burst
      add_desc(mk(4'h7, 32'h8000, 8'd7, 3'd3, 2'b01));
      a0 = acc_cnt;
      for (int i = 0; i < 20 && acc_cnt == a0; i++) step_cycle();
      check_eq("midrst_first_beat", 64'(acc_cnt - a0), 64'd1);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      prev_stall = 0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      use_dir = 1; dir_size = 3'd1;
      dir_addr = '{32'h9002, 32'h9004};
      add_desc(mk(4'hC, 32'h9002, 8'd1, 3'd1, 2'b01));
      drain();
      use_dir = 0;

      // Randomized traffic against the reference expansion
      ready_mode = 1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 2) == 0 && fifo.size() < 4) begin
            logic [7:0] len;
            logic [AW-1:0] addr;
            case ($urandom_range(0, 2))
               0: len = 8'($urandom_range(0, 3));
               1: len = 8'((1 << $urandom_range(1, 4)) - 1);
               default: len = 8'($urandom_range(0, 20));
            endcase
            addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom);
            d = mk(4'($urandom), addr, len, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) d.atop = 6'($urandom_range(1, 63));
            add_desc(d);
         end
         step_cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
